// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: mode encodings and FSM states.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SOLID,
    ST_BLINK,
    ST_BR_UP,
    ST_BR_DOWN
  } led_state_e;

  // Both breathe directions report as the single BREATHE mode.
  function automatic logic [1:0] state_to_mode(input led_state_e s);
    case (s)
      ST_SOLID:              return MODE_SOLID;
      ST_BLINK:              return MODE_BLINK;
      ST_BR_UP, ST_BR_DOWN:  return MODE_BREATHE;
      default:               return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/edge_rise_detect.sv
// 1-bit rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module edge_rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember the previous sample so a rise is "high now, low last cycle".
  always_ff @(posedge clk) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/led_pattern_driver.sv
// Single-LED driver: OFF / SOLID PWM / BLINK / BREATHE ramp, with mode changes
// handshaked in and applied only at the counter wrap so PWM never glitches.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned DUTY_STEP  = 8,
  parameter logic [7:0]  SOLID_DUTY = 8'd192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] counter_in,
  input  logic       blink_in,
  input  logic [1:0] mode_req,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       led,
  output logic [7:0] duty,
  output logic [1:0] mode_cur
);

  localparam logic [8:0] STEP9 = 9'(DUTY_STEP);
  localparam logic [7:0] STEP8 = 8'(DUTY_STEP);

  led_state_e state_q;
  logic [7:0] duty_q;
  logic       led_q;
  logic       led_d;
  logic       pend_vld_q;
  logic [1:0] pend_mode_q;
  logic       blink_rise;
  logic       accept;
  logic       apply;
  logic [8:0] up_sum;

  edge_rise_detect u_blink_rise (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_i  (blink_in),
    .rise_o (blink_rise)
  );

  // A pending request blocks new ones; it is applied only when the counter
  // is at FF, so a request accepted in the FF cycle waits a full wrap.
  assign accept = mode_valid & ~pend_vld_q;
  assign apply  = pend_vld_q & (counter_in == 8'hFF);
  assign up_sum = {1'b0, duty_q} + STEP9;

  // LED drive for the next cycle, from the current state and inputs.
  always_comb begin
    led_d = 1'b0;
    case (state_q)
      ST_OFF:   led_d = 1'b0;
      ST_BLINK: led_d = blink_in;
      default:  led_d = (counter_in < duty_q);
    endcase
  end

  // Mode FSM, duty ramp, pending request and registered LED output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      duty_q      <= 8'd0;
      led_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= MODE_OFF;
    end else begin
      led_q <= led_d;
      if (apply) begin
        // Mode apply wins over a coincident blink rise.
        pend_vld_q <= 1'b0;
        case (pend_mode_q)
          MODE_SOLID:   begin state_q <= ST_SOLID; duty_q <= SOLID_DUTY; end
          MODE_BLINK:   begin state_q <= ST_BLINK; duty_q <= 8'd0;       end
          MODE_BREATHE: begin state_q <= ST_BR_UP; duty_q <= 8'd0;       end
          default:      begin state_q <= ST_OFF;   duty_q <= 8'd0;       end
        endcase
      end else begin
        if (accept) begin
          pend_vld_q  <= 1'b1;
          pend_mode_q <= mode_req;
        end
        if (blink_rise) begin
          case (state_q)
            ST_BR_UP: begin
              if (up_sum > 9'd255) begin
                duty_q  <= 8'd255;
                state_q <= ST_BR_DOWN;
              end else begin
                duty_q  <= up_sum[7:0];
              end
            end
            ST_BR_DOWN: begin
              if (duty_q < STEP8) begin
                duty_q  <= 8'd0;
                state_q <= ST_BR_UP;
              end else begin
                duty_q  <= duty_q - STEP8;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mode_ready = ~pend_vld_q;
  assign led        = led_q;
  assign duty       = duty_q;
  assign mode_cur   = state_to_mode(state_q);

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with hand-derived expectations.
module tb_led_pattern_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cnt;
  logic       blink;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       mode_ready;
  logic       led;
  logic [7:0] duty;
  logic [1:0] mode_cur;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_pattern_driver #(
    .DUTY_STEP (8),
    .SOLID_DUTY(8'd192)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .counter_in(cnt),
    .blink_in  (blink),
    .mode_req  (mode_req),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .led       (led),
    .duty      (duty),
    .mode_cur  (mode_cur)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: outputs settle after the edge, then the free-running counter advances.
  task automatic step();
    @(posedge clk);
    #1;
    cnt   = cnt + 8'd1;
    blink = cnt[7];
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int g = 0;
    while (cnt != v && g < 300) begin
      step();
      g++;
    end
    if (cnt != v) check_val("wait_cnt", {24'd0, cnt}, {24'd0, v});
  endtask

  task automatic request(input logic [1:0] m);
    mode_req   = m;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
  endtask

  // Breathe duty after k rises with step 8: up 0..248, 255, down 247..7, 0, up again.
  function automatic int exp_duty(input int k);
    if (k <= 31)      return 8 * k;
    else if (k == 32) return 255;
    else if (k <= 63) return 255 - 8 * (k - 32);
    else if (k == 64) return 0;
    else              return 8 * (k - 64);
  endfunction

  initial begin
    int bad;
    int bad2;
    int highs;
    int lat;
    logic prev;

    reset_n    = 1'b0;
    cnt        = 8'd0;
    blink      = 1'b0;
    mode_req   = 2'b00;
    mode_valid = 1'b0;
    step();
    step();
    check_val("rst_led", led, 0);
    check_val("rst_duty", duty, 0);
    check_val("rst_mode", mode_cur, 0);
    check_val("rst_ready", mode_ready, 1);
    reset_n = 1'b1;

    // Idle: nothing may move without a request.
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (led !== 1'b0 || duty !== 8'd0 || mode_cur !== 2'b00 || mode_ready !== 1'b1) bad++;
    end
    check_val("idle_viol", bad, 0);

    // SOLID requested at counter 10.
    wait_cnt(8'h10);
    request(2'b01);
    check_val("solid_ready_low", mode_ready, 0);
    bad = 0;
    while (cnt != 8'hFF) begin
      if (mode_ready !== 1'b0 || mode_cur !== 2'b00) bad++;
      step();
    end
    check_val("solid_pending_viol", bad, 0);
    check_val("solid_not_yet", mode_cur, 0);
    step();
    check_val("solid_mode", mode_cur, 1);
    check_val("solid_duty", duty, 192);
    check_val("solid_ready_back", mode_ready, 1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led === 1'b1) highs++;
    end
    check_val("solid_highs", highs, 192);

    // BLINK: led follows blink_in one cycle late.
    request(2'b10);
    wait_cnt(8'hFF);
    step();
    check_val("blink_mode", mode_cur, 2);
    check_val("blink_duty", duty, 0);
    bad = 0;
    bad2 = 0;
    for (int i = 0; i < 300; i++) begin
      prev = blink;
      step();
      if (led !== prev) bad++;
      if (duty !== 8'd0) bad2++;
    end
    check_val("blink_follow", bad, 0);
    check_val("blink_duty_hold", bad2, 0);

    // BREATHE: triangular ramp, one step per blink rise (counter 7F -> 80).
    request(2'b11);
    wait_cnt(8'hFF);
    step();
    check_val("br_mode", mode_cur, 3);
    check_val("br_duty0", duty, 0);
    for (int k = 1; k <= 70; k++) begin
      wait_cnt(8'h80);
      check_val($sformatf("br_pre_k%0d", k), duty, exp_duty(k - 1));
      step();
      check_val($sformatf("br_k%0d", k), duty, exp_duty(k));
    end
    check_val("br_mode_end", mode_cur, 3);
    // duty is 48 here: counter 10 lights, counter 40 does not.
    wait_cnt(8'h10);
    step();
    check_val("br_led_on", led, 1);
    wait_cnt(8'h40);
    step();
    check_val("br_led_off", led, 0);

    // Reset mid-BREATHE with a SOLID request pending.
    wait_cnt(8'h20);
    request(2'b01);
    check_val("rstmid_pending", mode_ready, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_val("rstmid_duty", duty, 0);
    check_val("rstmid_led", led, 0);
    check_val("rstmid_mode", mode_cur, 0);
    check_val("rstmid_ready", mode_ready, 1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (mode_cur !== 2'b00 || duty !== 8'd0 || led !== 1'b0) bad++;
    end
    check_val("rstmid_never_applied", bad, 0);

    // Request accepted in the FF cycle waits a full wrap; a second one is ignored.
    wait_cnt(8'hFF);
    request(2'b01);
    check_val("ff_no_change", mode_cur, 0);
    check_val("ff_ready_low", mode_ready, 0);
    lat = 0;
    mode_req   = 2'b10;
    mode_valid = 1'b1;
    step();
    lat++;
    mode_valid = 1'b0;
    while (mode_cur === 2'b00 && lat < 300) begin
      step();
      lat++;
    end
    check_val("ff_latency", lat, 256);
    check_val("ff_mode", mode_cur, 1);
    check_val("ff_duty", duty, 192);
    check_val("ff_ready_back", mode_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_driver.md
# led_pattern_driver

Downstream consumer of the free-running 8-bit counter and its MSB blink output, sampling both each clock. Drives a single LED pin in one of four modes: off, solid with a fixed PWM duty, plain blink, or breathing with a triangular duty ramp. Mode changes arrive over a valid/ready handshake. They take effect only at a counter wrap, so the PWM waveform never glitches.

## Interface
- `DUTY_STEP`, default 8: duty increment/decrement per breathe step, range 1..255.
- `SOLID_DUTY`, default 8'd192: PWM compare value used in SOLID mode.
- `clk`, in, 1: clock; all state updates on its rising edge.
- `reset_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `counter_in`, in, 8: free-running counter value, incrementing by 1 per clock.
- `blink_in`, in, 1: counter MSB.
- `mode_req`, in, 2: requested mode. 00 OFF, 01 SOLID, 10 BLINK, 11 BREATHE.
- `mode_valid`, in, 1: request valid.
- `mode_ready`, out, 1: block can accept a request.
- `led`, out, 1: registered LED drive.
- `duty`, out, 8: current PWM compare value.
- `mode_cur`, out, 2: mode currently in effect.

## Operation
- Handshake: a request is accepted on any cycle where `mode_valid` and `mode_ready` are both 1.
  - On acceptance, `mode_req` is latched into a pending register and `mode_ready` drops to 0 on the next cycle.
  - `mode_req` is ignored while `mode_ready` is 0.
- Apply point: a pending request is applied in the cycle where `counter_in == 8'hFF`.
  - On the next edge, the FSM enters the new mode, `mode_cur` updates, pending clears, and `mode_ready` returns to 1.
  - A request accepted in a cycle where `counter_in == 8'hFF` is not applied in that same cycle. It waits for the following wrap, 256 cycles later.
- Same-mode requests go through the full handshake. Re-entering BREATHE restarts the ramp.
- FSM states: OFF, SOLID, BLINK, BREATHE_UP, BREATHE_DOWN.
  - OFF: `duty` = 0, `led` = 0.
  - SOLID: `duty` = `SOLID_DUTY`; `led` = (`counter_in` < `duty`).
  - BLINK: `duty` = 0; `led` = `blink_in`.
  - Entering BREATHE: `duty` = 0, state BREATHE_UP.
- Blink rise = `blink_in` & ~`blink_q`, where `blink_q` is `blink_in` registered one cycle.
- On each blink rise in BREATHE_UP:
  - if `duty` + `DUTY_STEP` > 255 (9-bit sum): `duty` = 255 and go to BREATHE_DOWN;
  - else `duty` += `DUTY_STEP`.
- On each blink rise in BREATHE_DOWN:
  - if `duty` < `DUTY_STEP`: `duty` = 0 and go to BREATHE_UP;
  - else `duty` -= `DUTY_STEP`.
- In both BREATHE states, `led` = (`counter_in` < `duty`).
- Simultaneous mode apply and blink rise: the mode apply wins and the ramp step is discarded.
- `duty` = 0 yields a constant 0. `duty` = 255 is high for 255 of every 256 cycles.

## Timing
- Reset values:
  - `led` = 0, `duty` = 0, `mode_cur` = OFF, `mode_ready` = 1;
  - pending cleared, `blink_q` = 0, FSM in OFF.
- Reset asserted mid-operation takes effect on the next edge and discards any pending request.
- `led` latency: one cycle. `led`(t+1) is computed from `counter_in`(t), `blink_in`(t) and `duty`(t).
- `duty` updates on the edge after the blink-rise cycle.
- Request-to-apply latency: from the acceptance edge to the first edge at which `counter_in` was FF, 1..256 cycles.
- `mode_cur` and `duty` change on the same edge. `led` reflects the new mode from the following cycle.

## Structure
- Shared package `led_pkg` holds:
  - mode encoding constants `MODE_OFF`, `MODE_SOLID`, `MODE_BLINK`, `MODE_BREATHE`;
  - the FSM state typedef.
- One natural sub-module, `edge_rise_detect`: a 1-bit registered rising-edge detector with synchronous active-low reset, used for the blink rise.
- PWM compare, duty ramp and handshake logic stay in the top module.

## Test plan
- Reset, then hold `mode_valid` = 0 for 600 cycles → `led` = 0, `duty` = 0, `mode_cur` = 00, `mode_ready` = 1 throughout.
- Request SOLID when `counter_in` = 8'h10 → `mode_ready` is 0 until after `counter_in` = FF; `mode_cur` = 01 on the next edge. Over the next 256 cycles, `led` is high for exactly 192.
- Request BLINK → after apply, `led` equals `blink_in` delayed one cycle; `duty` = 0.
- Request BREATHE, run 70 blink rises → `duty` goes 0, 8, …, 248, then 255 (state DOWN), then 247, 239, …; at most one step per rise.
- Request accepted in the `counter_in` = FF cycle → no change at that wrap; applied at the next wrap, 256 cycles later. A second `mode_valid` while `mode_ready` = 0 is ignored.
- Assert `reset_n` = 0 for one cycle mid-BREATHE with a request pending → next cycle `duty` = 0, `led` = 0, `mode_cur` = 00, `mode_ready` = 1, and the pending mode is never applied.
